// File: rtl/uart_tx_gen.sv
// APB UART transmitter: TX FIFO feeding a start/data/parity/stop serialiser paced by
// the shared oversample tick, with CTS auto-flow, break and per-frame line settings.
module uart_tx_gen #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [7:0]       PWDATA,
  input  logic             tx_fifo_push,
  input  logic             tx_fifo_clear,
  input  logic [7:0]       LCR,
  input  logic             enable,
  input  logic             afe,
  input  logic             cts_n,
  output logic             tx_fifo_empty,
  output logic             tx_fifo_full,
  output logic [CNT_W-1:0] tx_fifo_count,
  output logic             tx_overflow,
  output logic             tx_done,
  output logic             busy,
  output logic             TXD
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, full_q, ovf_q, done_q, busy_q, txd_q, txd_d;
  state_t           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic [5:0]       cfg_q, cfg_d;
  logic             start_ok_s, launch_s, push_ok_s, ovf_s;
  logic             bit_end_s, data_last_s, stop_last_s;
  logic             unused_lcr_s;

  assign unused_lcr_s = LCR[7];

  // Parity over the frame's data bits only; word length and mode come from cfg.
  function automatic logic frame_parity(input logic [7:0] data, input logic [5:0] cfg);
    logic [7:0] mask;
    logic       p;
    case (cfg[1:0])
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    case (cfg[5:3])
      3'b001:  p = ~^(data & mask);
      3'b011:  p = ^(data & mask);
      3'b101:  p = 1'b1;
      3'b111:  p = 1'b0;
      default: p = 1'b1;
    endcase
    return p;
  endfunction

  assign start_ok_s  = ~empty_q & enable & ~(afe & cts_n) & ~LCR[6] & ~tx_fifo_clear;
  assign bit_end_s   = enable & (tick_q == TW'(OVERSAMPLE - 1));
  assign data_last_s = (bit_q == (3'd4 + {1'b0, cfg_q[1:0]}));
  assign stop_last_s = (state_q == S_STOP) & bit_end_s & (bit_q == {2'b00, cfg_q[2]});
  assign launch_s    = start_ok_s & ((state_q == S_IDLE) | stop_last_s);
  assign push_ok_s   = tx_fifo_push & ~tx_fifo_clear & (~full_q | launch_s);
  assign ovf_s       = tx_fifo_push & ~tx_fifo_clear & full_q & ~launch_s;

  // FIFO pointer and occupancy next-state; clear wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (tx_fifo_clear) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_d = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = launch_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push_ok_s, launch_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge PCLK) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= PWDATA;
    end
  end

  // Frame state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (launch_s) state_d = S_START; else state_d = S_IDLE;
      S_START:  if (bit_end_s) state_d = S_DATA; else state_d = S_START;
      S_DATA: begin
        if (bit_end_s && data_last_s) state_d = cfg_q[3] ? S_PARITY : S_STOP;
        else state_d = S_DATA;
      end
      S_PARITY: if (bit_end_s) state_d = S_STOP; else state_d = S_PARITY;
      S_STOP: begin
        if (stop_last_s) state_d = launch_s ? S_START : S_IDLE;
        else state_d = S_STOP;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Bit timing, frame capture and serial line value; break masks the line only.
  always_comb begin
    tick_d = tick_q;
    bit_d  = bit_q;
    data_d = data_q;
    cfg_d  = cfg_q;
    if (launch_s) begin
      tick_d = {TW{1'b0}};
      bit_d  = 3'd0;
      data_d = mem_q[rd_ptr_q];
      cfg_d  = LCR[5:0];
    end else if ((state_q != S_IDLE) && enable) begin
      if (bit_end_s) begin
        tick_d = {TW{1'b0}};
        if (state_q == S_DATA) begin
          bit_d = data_last_s ? 3'd0 : bit_q + 3'd1;
        end else if (state_q == S_STOP) begin
          bit_d = stop_last_s ? 3'd0 : bit_q + 3'd1;
        end else begin
          bit_d = bit_q;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end else begin
      tick_d = tick_q;
    end
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = data_d[bit_d];
      S_PARITY: txd_d = frame_parity(data_d, cfg_d);
      default:  txd_d = 1'b1;
    endcase
    txd_d = txd_d & ~LCR[6];
  end

  // Datapath and registered outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tick_q   <= {TW{1'b0}};
      bit_q    <= 3'd0;
      data_q   <= 8'h00;
      cfg_q    <= 6'h00;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == {CNT_W{1'b0}});
      full_q   <= (count_d == CNT_W'(FIFO_DEPTH));
      ovf_q    <= ovf_s;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      cfg_q    <= cfg_d;
      txd_q    <= txd_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= stop_last_s;
    end
  end

  assign tx_fifo_empty = empty_q;
  assign tx_fifo_full  = full_q;
  assign tx_fifo_count = count_q;
  assign tx_overflow   = ovf_q;
  assign tx_done       = done_q;
  assign busy          = busy_q;
  assign TXD           = txd_q;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen: frame shapes, FIFO limits, flow control, break, reset.
module tb_uart_tx_gen;

  localparam int DEPTH = 4;
  localparam int OS    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [7:0]    PWDATA;
  logic          tx_fifo_push, tx_fifo_clear;
  logic [7:0]    LCR;
  logic          enable, afe, cts_n;
  logic          tx_fifo_empty, tx_fifo_full, tx_overflow, tx_done, busy, TXD;
  logic [CW-1:0] tx_fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_gen #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PWDATA(PWDATA),
    .tx_fifo_push(tx_fifo_push), .tx_fifo_clear(tx_fifo_clear),
    .LCR(LCR), .enable(enable), .afe(afe), .cts_n(cts_n),
    .tx_fifo_empty(tx_fifo_empty), .tx_fifo_full(tx_fifo_full),
    .tx_fifo_count(tx_fifo_count), .tx_overflow(tx_overflow),
    .tx_done(tx_done), .busy(busy), .TXD(TXD)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    tx_fifo_push = 1'b1;
    PWDATA       = d;
    @(negedge PCLK);
    tx_fifo_push = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (TXD !== 1'b0 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    check_eq({tag, "_start"}, 32'(TXD), 32'd0);
  endtask

  // bits[i] is the line level of bit period i, start bit first.
  task automatic run_frame(input string tag, input logic [11:0] bits, input int nbits, input bit b2b);
    wait_start(tag);
    for (int c = 1; c <= OS * nbits + 1; c++) begin
      if (c > 1) @(negedge PCLK);
      if (c == 1) check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      if (c <= OS * nbits) begin
        if (((c - 1) % OS == 0) || (c % OS == 0))
          check_eq($sformatf("%s_bit%0d", tag, (c - 1) / OS), 32'(TXD), 32'(bits[(c - 1) / OS]));
        if (c == OS * nbits) check_eq({tag, "_done_early"}, 32'(tx_done), 32'd0);
      end else begin
        check_eq({tag, "_done"}, 32'(tx_done), 32'd1);
        check_eq({tag, "_busy_end"}, 32'(busy), 32'(b2b));
        check_eq({tag, "_txd_end"}, 32'(TXD), 32'(!b2b));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    PRESETn = 1'b1; PWDATA = 8'h00; tx_fifo_push = 1'b0; tx_fifo_clear = 1'b0;
    LCR = 8'h03; enable = 1'b1; afe = 1'b0; cts_n = 1'b0;
    #1 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    check_eq("rst_txd",   32'(TXD),           32'd1);
    check_eq("rst_busy",  32'(busy),          32'd0);
    check_eq("rst_empty", 32'(tx_fifo_empty), 32'd1);
    check_eq("rst_full",  32'(tx_fifo_full),  32'd0);
    check_eq("rst_count", 32'(tx_fifo_count), 32'd0);
    check_eq("rst_done",  32'(tx_done),       32'd0);
    check_eq("rst_ovf",   32'(tx_overflow),   32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_eq("idle_txd", 32'(TXD), 32'd1);

    // 8N1 0xA5
    push_byte(8'hA5);
    run_frame("a5_8n1", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);
    // 8E1 0x07: three ones, even parity bit 1
    LCR = 8'h1B;
    push_byte(8'h07);
    run_frame("07_8e1", {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0);
    // 7O1 0x7F: seven ones, odd parity bit 0
    LCR = 8'h0A;
    push_byte(8'h7F);
    run_frame("7f_7o1", {2'b00, 1'b1, 1'b0, 7'h7F, 1'b0}, 10, 1'b0);
    // 5 bits, stick-1 parity, two stop bits
    LCR = 8'h2C;
    push_byte(8'h00);
    run_frame("00_5m2", {3'b000, 2'b11, 1'b1, 5'h00, 1'b0}, 9, 1'b0);

    // FIFO fill, overflow, push+pop at full, clear
    LCR = 8'h03; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_byte(vals[i]);
      check_eq($sformatf("fifo_cnt%0d", i), 32'(tx_fifo_count), (i < 4) ? i + 1 : 4);
      check_eq($sformatf("fifo_ovf%0d", i), 32'(tx_overflow), (i == 4) ? 32'd1 : 32'd0);
    end
    check_eq("fifo_full",  32'(tx_fifo_full),  32'd1);
    check_eq("fifo_empty", 32'(tx_fifo_empty), 32'd0);
    @(negedge PCLK);
    check_eq("ovf_pulse", 32'(tx_overflow), 32'd0);
    enable = 1'b1; tx_fifo_push = 1'b1; PWDATA = 8'h66;
    @(negedge PCLK);
    enable = 1'b0; tx_fifo_push = 1'b0;
    check_eq("pp_count", 32'(tx_fifo_count), 32'd4);
    check_eq("pp_full",  32'(tx_fifo_full),  32'd1);
    check_eq("pp_ovf",   32'(tx_overflow),   32'd0);
    check_eq("pp_busy",  32'(busy),          32'd1);
    tx_fifo_clear = 1'b1;
    @(negedge PCLK);
    tx_fifo_clear = 1'b0;
    check_eq("clr_count", 32'(tx_fifo_count), 32'd0);
    check_eq("clr_empty", 32'(tx_fifo_empty), 32'd1);
    check_eq("clr_full",  32'(tx_fifo_full),  32'd0);
    enable = 1'b1;
    run_frame("clr_frame", {2'b00, 1'b1, 8'h11, 1'b0}, 10, 1'b0);

    // CTS hold-off then back-to-back release
    afe = 1'b1; cts_n = 1'b1;
    push_byte(8'h55);
    push_byte(8'h3C);
    repeat (40) @(negedge PCLK);
    check_eq("cts_txd",   32'(TXD),           32'd1);
    check_eq("cts_busy",  32'(busy),          32'd0);
    check_eq("cts_count", 32'(tx_fifo_count), 32'd2);
    cts_n = 1'b0;
    run_frame("b2b_55", {2'b00, 1'b1, 8'h55, 1'b0}, 10, 1'b1);
    run_frame("b2b_3c", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 1'b0);
    afe = 1'b0;

    // word length change mid-frame is ignored
    push_byte(8'hC3);
    fork
      run_frame("lcr_mid", {2'b00, 1'b1, 8'hC3, 1'b0}, 10, 1'b0);
      begin
        repeat (30) @(negedge PCLK);
        LCR = 8'h00;
      end
    join
    LCR = 8'h03;

    // break mid-frame masks TXD without disturbing timing
    push_byte(8'hFF);
    wait_start("brk");
    for (int c = 1; c <= 161; c++) begin
      if (c > 1) @(negedge PCLK);
      if (c == 20) check_eq("brk_before", 32'(TXD), 32'd1);
      if (c == 21 || c == 60) check_eq($sformatf("brk_low%0d", c), 32'(TXD), 32'd0);
      if (c == 61) check_eq("brk_resume", 32'(TXD), 32'd1);
      if (c == 160) check_eq("brk_done_early", 32'(tx_done), 32'd0);
      if (c == 161) begin
        check_eq("brk_done", 32'(tx_done), 32'd1);
        check_eq("brk_busy", 32'(busy),    32'd0);
      end
      if (c == 20) LCR = 8'h43;
      if (c == 60) LCR = 8'h03;
    end

    // asynchronous reset in the middle of the data bits
    push_byte(8'h00);
    push_byte(8'h00);
    wait_start("arst");
    repeat (40) @(negedge PCLK);
    check_eq("arst_pre_txd", 32'(TXD), 32'd0);
    @(posedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    check_eq("arst_txd",  32'(TXD),  32'd1);
    check_eq("arst_busy", 32'(busy), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_eq("arst_empty", 32'(tx_fifo_empty), 32'd1);
    check_eq("arst_count", 32'(tx_fifo_count), 32'd0);
    repeat (5) @(negedge PCLK);
    check_eq("arst_idle_busy", 32'(busy), 32'd0);
    check_eq("arst_idle_txd",  32'(TXD),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_gen.md
Name: uart_tx_gen

Overview:
Parametrised next-generation APB UART transmitter. It contains an internal TX FIFO of configurable depth and a configurable oversample ratio. Each frame's line settings are captured at frame start. It adds CTS auto-flow control, break generation, FIFO clear, overflow detection and a frame-done pulse. It sits between the APB register block (which supplies PWDATA/LCR/push) and the TXD pin, driven by the shared baud-rate `enable` tick.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of 2, 2..256
OVERSAMPLE, 16, `enable` ticks per bit period; 2..256
CNT_W, $clog2(FIFO_DEPTH)+1, width of tx_fifo_count (derived, not overridden)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
PWDATA  in  8  byte to push into TX FIFO
tx_fifo_push  in  1  push PWDATA this cycle
tx_fifo_clear  in  1  flush FIFO (single-cycle pulse)
LCR  in  8  [1:0] word length 5/6/7/8; [2] 2 stop bits; [3] parity en; [4] even; [5] stick; [6] break
enable  in  1  baud oversample tick
afe  in  1  auto flow enable
cts_n  in  1  clear-to-send, active-low, already synchronised
tx_fifo_empty  out  1  FIFO empty
tx_fifo_full  out  1  FIFO full
tx_fifo_count  out  CNT_W  entries held, 0..FIFO_DEPTH
tx_overflow  out  1  1-cycle pulse: push dropped
tx_done  out  1  1-cycle pulse: frame's last stop tick consumed
busy  out  1  frame in progress
TXD  out  1  serial output

Behaviour:
- Reset (async, PRESETn=0): FIFO empty, count=0, state IDLE, TXD=1, busy=0, tx_done=0, tx_overflow=0, bit counter=0. Reset mid-frame aborts the frame; TXD returns to 1 without waiting for a clock.
- FIFO:
  - Push when not full writes PWDATA.
  - Push when full and no pop that cycle: data dropped, tx_overflow=1 next cycle.
  - Push+pop in the same cycle: count unchanged. This is legal when full.
  - tx_fifo_clear: count=0 next cycle and overrides a same-cycle push/pop. A frame in flight completes from its shift register.
  - Pointers wrap modulo FIFO_DEPTH.
  - Status outputs are registered from count.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when !tx_fifo_empty & enable & !(afe & cts_n). That cycle: pop FIFO head into shift register, latch LCR[5:0] into a frame config register, clear bit counter, busy=1.
  - TXD goes 0 on the cycle after the transition.
- Bit timing: each bit lasts exactly OVERSAMPLE `enable` ticks. The counter advances only on enable. The state advances on the tick where counter=OVERSAMPLE-1, then the counter wraps to 0. With enable held high, each bit is OVERSAMPLE PCLK cycles.
- START→DATA. DATA sends bits LSB first; the data count is 5+cfg[1:0].
  - After the last data bit: PARITY if cfg[3], else STOP.
- PARITY value is computed over the sent data bits only:
  - cfg[5:3]=001 → odd (~^)
  - 011 → even (^)
  - 101 → 1
  - 111 → 0
- STOP sends TXD=1 for 1 bit period, or 2 if cfg[2].
  - On the final tick: tx_done=1 for one cycle.
  - If the start condition holds at that point, go directly to START (back-to-back, no idle bit). Otherwise go to IDLE with busy=0 on the next cycle.
- Flow control: CTS is checked only at frame start. cts_n rising mid-frame does not interrupt the frame.
- Break: while live LCR[6]=1, TXD is forced to 0 and no new frame starts. A frame in progress continues its timing with TXD masked to 0. On LCR[6] falling, TXD resumes normal value next cycle.
- LCR changes mid-frame do not affect the current frame, except bit 6.
- enable=0 freezes bit timing indefinitely. The FIFO remains fully operational.

Test Plan:
- Reset, OVERSAMPLE=16, LCR=0x03, enable=1, push 0xA5 → TXD after start: 0,1,0,1,0,0,1,0,1,1. Each level lasts 16 cycles. tx_done pulses once at cycle 160 after start. busy returns 0.
- LCR=0x1B (8E1), push 0x07 → parity bit = 1. LCR=0x0A (7O1), push 0x7F → 7 data bits of 1, parity 0, one stop bit.
- FIFO_DEPTH=4: push 5 bytes with enable=0 → count=4, full=1, tx_overflow pulses on the 5th push. Then push+pop in the same cycle at full → count stays 4. Clear → count 0, empty=1.
- afe=1, cts_n=1, 2 bytes queued → TXD stays 1 and busy=0. Set cts_n=0 → both frames sent back-to-back, no idle between the stop bit and the next start.
- Mid-frame: change LCR from 0x03 to 0x00 → current frame still 8 bits. Set LCR[6]=1 → TXD=0 until cleared, frame timing unchanged.
- Assert PRESETn=0 mid-DATA → TXD=1 and busy=0 asynchronously. FIFO empty after release.
